// File: rtl/gearbox_fifo_if.sv
// Handshake and status bundle for gearbox_fifo: the master drives requests, the slave (FIFO) returns data and flags.
interface gearbox_fifo_if #(
    parameter int unsigned LANE_W     = 64,
    parameter int unsigned IN_LANES   = 2,
    parameter int unsigned OUT_LANES  = 3,
    parameter int unsigned DEPTH_LOG2 = 10
);
    logic                          flush;
    logic                          wr;
    logic [IN_LANES*LANE_W-1:0]    data_in;
    logic                          rd;
    logic [DEPTH_LOG2:0]           thresh_lvl;
    logic                          err_clr;
    logic [OUT_LANES*LANE_W-1:0]   data_out;
    logic                          out_valid;
    logic                          rd_strobe;
    logic                          full;
    logic                          empty;
    logic                          threshold;
    logic                          overflow;
    logic                          underflow;
    logic [DEPTH_LOG2:0]           level;

    modport master (
        output flush, wr, data_in, rd, thresh_lvl, err_clr,
        input  data_out, out_valid, rd_strobe, full, empty, threshold,
               overflow, underflow, level
    );

    modport slave (
        input  flush, wr, data_in, rd, thresh_lvl, err_clr,
        output data_out, out_valid, rd_strobe, full, empty, threshold,
               overflow, underflow, level
    );
endinterface

// File: rtl/gearbox_fifo.sv
// Lane-granular ring buffer: IN_LANES lanes per write, OUT_LANES lanes per paced read, lane 0 in the MSBs.
module gearbox_fifo #(
    parameter int unsigned LANE_W     = 64,
    parameter int unsigned IN_LANES   = 2,
    parameter int unsigned OUT_LANES  = 3,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned CLK_DIV    = 30
) (
    input  logic            clk,
    input  logic            rstn,
    gearbox_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned OW    = OUT_LANES * LANE_W;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LVL_W-1:0]      lvl_t;

    logic [LANE_W-1:0] mem_q [DEPTH];

    ptr_t             wptr_q, wptr_d;
    ptr_t             rptr_q, rptr_d;
    lvl_t             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]    dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic tick, full, empty, wr_acc, rd_acc;

    assign tick   = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign full   = (level_q > lvl_t'(DEPTH - IN_LANES));
    assign empty  = (level_q < lvl_t'(OUT_LANES));
    assign wr_acc = bus.wr && !full && !bus.flush;
    assign rd_acc = bus.rd && tick && !empty && !bus.flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            cnt_d   = '0;
            dout_d  = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            cnt_d   = tick ? '0 : cnt_q + 1'b1;
            valid_d = rd_acc;
            if (wr_acc) wptr_d = wptr_q + ptr_t'(IN_LANES);
            if (rd_acc) begin
                rptr_d = rptr_q + ptr_t'(OUT_LANES);
                // Oldest lane lands in the MSB lane; index wraps naturally at DEPTH.
                for (int unsigned i = 0; i < OUT_LANES; i++)
                    dout_d[(OUT_LANES-1-i)*LANE_W +: LANE_W] = mem_q[rptr_q + ptr_t'(i)];
            end
            level_d = level_q + (wr_acc ? lvl_t'(IN_LANES) : '0)
                              - (rd_acc ? lvl_t'(OUT_LANES) : '0);
            if (bus.wr && full)              ovf_d = 1'b1;
            else if (bus.err_clr)            ovf_d = 1'b0;
            if (bus.rd && tick && empty)     udf_d = 1'b1;
            else if (bus.err_clr)            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is never reset; the pointers alone decide which lanes are valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int unsigned i = 0; i < IN_LANES; i++)
                mem_q[wptr_q + ptr_t'(i)] <= bus.data_in[(IN_LANES-1-i)*LANE_W +: LANE_W];
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.out_valid = valid_q;
    assign bus.rd_strobe = rd_acc;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.threshold = (level_q >= bus.thresh_lvl);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_gearbox_fifo.sv
// Scoreboard bench for gearbox_fifo: a lane-queue model predicts flags and read words every cycle.
module tb_gearbox_fifo;
    localparam int unsigned LANE_W     = 64;
    localparam int unsigned IN_LANES   = 2;
    localparam int unsigned OUT_LANES  = 3;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned OW         = OUT_LANES * LANE_W;
    localparam int unsigned IW         = IN_LANES * LANE_W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    gearbox_fifo_if #(.LANE_W(LANE_W), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES),
                      .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    gearbox_fifo #(.LANE_W(LANE_W), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES),
                   .DEPTH_LOG2(DEPTH_LOG2), .CLK_DIV(CLK_DIV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [LANE_W-1:0] lanes [$];
    logic [OW-1:0]     exp_q [$];
    int unsigned       mcnt   = 0;
    logic              movf   = 1'b0;
    logic              mudf   = 1'b0;
    logic              mvalid = 1'b0;
    logic [OW-1:0]     mdata  = '0;

    always @(negedge clk) begin : mon
        logic        tick, mfull, mempty, wacc, racc;
        logic [OW-1:0] w;
        int unsigned lvl;
        if (!rstn) begin
            check_eq("rst_level",  OW'(bus.level), '0);
            check_eq("rst_empty",  OW'(bus.empty), OW'(1));
            check_eq("rst_full",   OW'(bus.full), '0);
            check_eq("rst_dout",   bus.data_out, '0);
            check_eq("rst_valid",  OW'(bus.out_valid), '0);
            check_eq("rst_ovf",    OW'(bus.overflow), '0);
            check_eq("rst_udf",    OW'(bus.underflow), '0);
            check_eq("rst_strobe", OW'(bus.rd_strobe), '0);
            lanes.delete(); exp_q.delete();
            mcnt = 0; movf = 1'b0; mudf = 1'b0; mvalid = 1'b0; mdata = '0;
        end else begin
            lvl    = lanes.size();
            tick   = (mcnt == CLK_DIV - 1);
            mfull  = (lvl > DEPTH - IN_LANES);
            mempty = (lvl < OUT_LANES);
            wacc   = bus.wr && !mfull && !bus.flush;
            racc   = bus.rd && tick && !mempty && !bus.flush;
            check_eq("level",     OW'(bus.level), OW'(lvl));
            check_eq("full",      OW'(bus.full), OW'(mfull));
            check_eq("empty",     OW'(bus.empty), OW'(mempty));
            check_eq("threshold", OW'(bus.threshold), OW'(lvl >= int'(bus.thresh_lvl)));
            check_eq("overflow",  OW'(bus.overflow), OW'(movf));
            check_eq("underflow", OW'(bus.underflow), OW'(mudf));
            check_eq("out_valid", OW'(bus.out_valid), OW'(mvalid));
            check_eq("data_out",  bus.data_out, mdata);
            check_eq("rd_strobe", OW'(bus.rd_strobe), OW'(racc));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check_eq("sb_spurious", OW'(1), '0);
                else                   check_eq("sb_word", bus.data_out, exp_q.pop_front());
            end
            if (bus.flush) begin
                lanes.delete(); exp_q.delete();
                mcnt = 0; movf = 1'b0; mudf = 1'b0; mvalid = 1'b0; mdata = '0;
            end else begin
                mvalid = racc;
                if (racc) begin
                    for (int unsigned i = 0; i < OUT_LANES; i++)
                        w[(OUT_LANES-1-i)*LANE_W +: LANE_W] = lanes.pop_front();
                    mdata = w;
                    exp_q.push_back(w);
                end
                if (wacc)
                    for (int unsigned i = 0; i < IN_LANES; i++)
                        lanes.push_back(bus.data_in[(IN_LANES-1-i)*LANE_W +: LANE_W]);
                if (bus.wr && mfull)              movf = 1'b1;
                else if (bus.err_clr)             movf = 1'b0;
                if (bus.rd && tick && mempty)     mudf = 1'b1;
                else if (bus.err_clr)             mudf = 1'b0;
                mcnt = tick ? 0 : mcnt + 1;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1; step(1); bus.flush = 1'b0;
    endtask

    function automatic logic [IW-1:0] rnd_word();
        logic [IW-1:0] v;
        for (int unsigned i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic stream(input int unsigned cycles, input int unsigned flush_at);
        bus.rd = 1'b1;
        for (int unsigned c = 0; c < cycles; c++) begin
            bus.wr      = (lanes.size() < 600) && ($urandom_range(0, 1) == 1);
            bus.data_in = rnd_word();
            bus.flush   = (c == flush_at);
            step(1);
            if (c == flush_at) begin
                check_eq("flush_level", OW'(bus.level), '0);
                check_eq("flush_empty", OW'(bus.empty), OW'(1));
                check_eq("flush_dout",  bus.data_out, '0);
                check_eq("flush_flags", OW'({bus.overflow, bus.underflow, bus.out_valid}), '0);
            end
        end
        bus.flush = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    initial begin : stim
        logic [LANE_W-1:0] la, lb, lc, ld;
        logic seen;
        la = {16{4'hA}}; lb = {16{4'hB}}; lc = {16{4'hC}}; ld = {16{4'hD}};
        bus.flush = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.err_clr = 1'b0;
        bus.data_in = '0; bus.thresh_lvl = 11'd6;
        rstn = 1'b0;
        step(3);
        rstn = 1'b1;

        // Two writes, then paced read of the first 3-lane word.
        bus.wr = 1'b1; bus.data_in = {la, lb}; step(1);
        bus.data_in = {lc, ld}; step(1);
        bus.wr = 1'b0; bus.rd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (bus.out_valid) seen = 1'b1;
        end
        bus.rd = 1'b0;
        check_eq("seq_timeout", OW'(seen), OW'(1));
        check_eq("seq_word",    bus.data_out, {la, lb, lc});
        check_eq("seq_level",   OW'(bus.level), OW'(1));
        step(2);

        // Threshold crossing at 6 lanes.
        pulse_flush();
        bus.wr = 1'b1; bus.data_in = rnd_word(); step(1);
        bus.data_in = rnd_word(); step(1);
        bus.wr = 1'b0;
        check_eq("thr_lvl4", OW'({bus.level, bus.threshold}), OW'({11'd4, 1'b0}));
        bus.wr = 1'b1; bus.data_in = rnd_word(); step(1);
        bus.wr = 1'b0;
        check_eq("thr_lvl6", OW'({bus.level, bus.threshold}), OW'({11'd6, 1'b1}));

        // Underflow on empty, partial word still counts as empty.
        pulse_flush();
        bus.rd = 1'b1; step(8); bus.rd = 1'b0;
        check_eq("udf_set", OW'(bus.underflow), OW'(1));
        bus.wr = 1'b1; bus.data_in = rnd_word(); step(1); bus.wr = 1'b0;
        check_eq("udf_partial_empty", OW'({bus.empty, bus.level}), OW'({1'b1, 11'd2}));
        bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0;
        check_eq("udf_clr", OW'(bus.underflow), '0);

        // Fill to full, then overflow.
        pulse_flush();
        bus.wr = 1'b1;
        for (int i = 0; i < 515; i++) begin
            bus.data_in = rnd_word(); step(1);
        end
        bus.wr = 1'b0;
        check_eq("fill_state", OW'({bus.full, bus.overflow, bus.level}), OW'({1'b1, 1'b1, 11'd1024}));
        bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0;
        check_eq("ovf_clr", OW'(bus.overflow), '0);

        // Mixed traffic across pointer wrap, with a flush mid-stream.
        pulse_flush();
        stream(3600, 400);

        // Asynchronous reset mid-burst.
        bus.rd = 1'b1; bus.wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.data_in = rnd_word(); step(1);
        end
        rstn = 1'b0;
        #1;
        check_eq("arst_level", OW'(bus.level), '0);
        check_eq("arst_flags", OW'({bus.empty, bus.full, bus.out_valid, bus.overflow,
                                    bus.underflow, bus.rd_strobe}), OW'(6'b100000));
        check_eq("arst_dout",  bus.data_out, '0);
        bus.rd = 1'b0; bus.wr = 1'b0;
        step(2);
        rstn = 1'b1;
        stream(200, 1000);
        step(2 * CLK_DIV);
        check_eq("sb_drain", OW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
